// File: rtl/sram_sp_bytemask_if.sv
// Command/response bundle for the single-port byte-masked SRAM.
// The master drives commands and the clear request; the slave (the SRAM)
// returns read data, the read strobe and its ready flag.
interface sram_sp_bytemask_if #(
  parameter int DATA_W = 128,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 11
);
  logic                       CEN;
  logic                       WEN;
  logic [DATA_W/BYTE_W-1:0]   BEN;
  logic [ADDR_W-1:0]          A;
  logic [DATA_W-1:0]          D;
  logic                       CLR;
  logic [DATA_W-1:0]          Q;
  logic                       QV;
  logic                       READY;

  modport master (
    output CEN, WEN, BEN, A, D, CLR,
    input  Q, QV, READY
  );

  modport slave (
    input  CEN, WEN, BEN, A, D, CLR,
    output Q, QV, READY
  );
endinterface

// File: rtl/sram_sp_bytemask.sv
// Parametrised single-port synchronous SRAM with per-byte write mask,
// optional output register, read-valid strobe and a hardware clear sweep
// that fills every word with INIT_VAL after reset and on request.
module sram_sp_bytemask #(
  parameter int              DATA_W     = 128,
  parameter int              BYTE_W     = 8,
  parameter int              ADDR_W     = 11,
  parameter int              DEPTH      = 2048,
  parameter int              OUT_REG    = 0,
  parameter int              CLR_ON_RST = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                CLK,
  input  logic                RST,
  sram_sp_bytemask_if.slave   bus
);

  localparam int LANES = DATA_W / BYTE_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_RDY   = 2'd2
  } state_t;

  state_t               state;
  logic [ADDR_W-1:0]    cnt;
  logic                 ready_r;

  logic [DATA_W-1:0]    mem [DEPTH];

  logic                 in_range;
  logic                 cmd_go;
  logic                 wr_go;
  logic                 rd_go;
  logic                 sweep_we;
  logic [IDX_W-1:0]     a_idx;
  logic [IDX_W-1:0]     cnt_idx;

  logic [DATA_W-1:0]    rd_p0;
  logic                 vld_p0;
  logic [DATA_W-1:0]    rd_p1;
  logic                 vld_p1;

  // Addresses at or beyond DEPTH never touch the array; reads of them return 0.
  assign in_range = ({1'b0, bus.A} < (ADDR_W+1)'(DEPTH));
  assign a_idx    = bus.A[IDX_W-1:0];
  assign cnt_idx  = cnt[IDX_W-1:0];

  // A CLR in the ready state wins over any command issued in the same cycle.
  assign cmd_go   = (state == S_RDY) && !bus.CLR && !bus.CEN;
  assign wr_go    = cmd_go && !bus.WEN;
  assign rd_go    = cmd_go &&  bus.WEN;

  // Held reset must not write the array even though the state already reads SWEEP.
  assign sweep_we = (state == S_SWEEP) && !RST;

  // Control FSM: sweep address counter and registered READY flag.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= (CLR_ON_RST != 0) ? S_SWEEP : S_IDLE;
      cnt     <= '0;
      ready_r <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state   <= S_RDY;
          ready_r <= 1'b1;
        end
        S_SWEEP: begin
          if (cnt == ADDR_W'(DEPTH - 1)) begin
            state   <= S_RDY;
            ready_r <= 1'b1;
            cnt     <= '0;
          end else begin
            cnt <= cnt + ADDR_W'(1);
          end
        end
        S_RDY: begin
          if (bus.CLR) begin
            state   <= S_SWEEP;
            ready_r <= 1'b0;
            cnt     <= '0;
          end
        end
        default: begin
          state   <= S_SWEEP;
          ready_r <= 1'b0;
          cnt     <= '0;
        end
      endcase
    end
  end

  // Array write port: sweep fill, otherwise lane-masked command writes.
  always_ff @(posedge CLK) begin
    if (sweep_we) begin
      mem[cnt_idx] <= INIT_VAL;
    end else if (wr_go && in_range) begin
      for (int i = 0; i < LANES; i++) begin
        if (!bus.BEN[i]) begin
          mem[a_idx][i*BYTE_W +: BYTE_W] <= bus.D[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  // ---- stage p0: read capture at the command edge; holds until the next read ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_p0  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= rd_go;
      if (rd_go) begin
        rd_p0 <= in_range ? mem[a_idx] : '0;
      end
    end
  end

  // ---- stage p1: optional output flop; drains even if a sweep has started ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        rd_p1 <= rd_p0;
      end
    end
  end

  assign bus.Q     = (OUT_REG != 0) ? rd_p1  : rd_p0;
  assign bus.QV    = (OUT_REG != 0) ? vld_p1 : vld_p0;
  assign bus.READY = ready_r;

endmodule

// File: tb/tb_sram_sp_bytemask.sv
// Bench for sram_sp_bytemask: two instances share one stimulus stream.
// Instance A: DEPTH=16, latency 1. Instance B: DEPTH=12, latency 2.
module tb_sram_sp_bytemask;

  localparam int          DW   = 32;
  localparam int          AW   = 4;
  localparam logic [31:0] FILL = {4{8'hA5}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cen = 1'b1;
  logic        wen = 1'b1;
  logic [3:0]  ben = 4'hF;
  logic [3:0]  a   = '0;
  logic [31:0] d   = '0;
  logic        clr = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  sram_sp_bytemask_if #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW)) bus_a ();
  sram_sp_bytemask_if #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW)) bus_b ();

  assign bus_a.CEN = cen;  assign bus_b.CEN = cen;
  assign bus_a.WEN = wen;  assign bus_b.WEN = wen;
  assign bus_a.BEN = ben;  assign bus_b.BEN = ben;
  assign bus_a.A   = a;    assign bus_b.A   = a;
  assign bus_a.D   = d;    assign bus_b.D   = d;
  assign bus_a.CLR = clr;  assign bus_b.CLR = clr;

  sram_sp_bytemask #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .DEPTH(16),
                     .OUT_REG(0), .CLR_ON_RST(1), .INIT_VAL(FILL))
    dut_a (.CLK(clk), .RST(rst), .bus(bus_a));

  sram_sp_bytemask #(.DATA_W(DW), .BYTE_W(8), .ADDR_W(AW), .DEPTH(12),
                     .OUT_REG(1), .CLR_ON_RST(1), .INIT_VAL(FILL))
    dut_b (.CLK(clk), .RST(rst), .bus(bus_b));

  always #5 clk = ~clk;

  // Behavioural model: one entry per instance.
  int          m_depth [2] = '{16, 12};
  int          m_lat   [2] = '{1, 2};
  logic [31:0] m_mem   [2][16];
  bit          m_ready [2];
  int          m_pos   [2];
  logic [31:0] m_q     [2];
  bit          m_qv    [2];
  bit          m_pv    [2];
  logic [31:0] m_pd    [2];

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit          rd;
      logic [31:0] rdat;
      rd   = 1'b0;
      rdat = '0;
      if (rst) begin
        m_ready[k] = 1'b0; m_pos[k] = 0;
        m_q[k] = '0; m_qv[k] = 1'b0; m_pv[k] = 1'b0; m_pd[k] = '0;
      end else begin
        if (!m_ready[k]) begin
          m_mem[k][m_pos[k]] = FILL;
          m_pos[k]++;
          if (m_pos[k] == m_depth[k]) begin
            m_ready[k] = 1'b1;
            m_pos[k]   = 0;
          end
        end else if (clr) begin
          m_ready[k] = 1'b0;
          m_pos[k]   = 0;
        end else if (!cen) begin
          if (!wen) begin
            if (int'(a) < m_depth[k])
              for (int i = 0; i < 4; i++)
                if (!ben[i]) m_mem[k][a][i*8 +: 8] = d[i*8 +: 8];
          end else begin
            rd   = 1'b1;
            rdat = (int'(a) < m_depth[k]) ? m_mem[k][a] : 32'h0;
          end
        end
        if (m_lat[k] == 1) begin
          m_qv[k] = rd;
          if (rd) m_q[k] = rdat;
        end else begin
          m_qv[k] = m_pv[k];
          if (m_pv[k]) m_q[k] = m_pd[k];
          m_pv[k] = rd;
          m_pd[k] = rdat;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic pin(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mdl_v, input logic [31:0] exp);
    chk(name, dut_v, exp);
    chk({name, "_model"}, mdl_v, exp);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("a_q",     bus_a.Q,     m_q[0]);
    chk("a_qv",    32'(bus_a.QV),    32'(m_qv[0]));
    chk("a_ready", 32'(bus_a.READY), 32'(m_ready[0]));
    chk("b_q",     bus_b.Q,     m_q[1]);
    chk("b_qv",    32'(bus_b.QV),    32'(m_qv[1]));
    chk("b_ready", 32'(bus_b.READY), 32'(m_ready[1]));
  end

  task automatic cmd(input bit c_cen, input bit c_wen, input logic [3:0] c_ben,
                     input logic [3:0] c_a, input logic [31:0] c_d, input bit c_clr);
    cen = c_cen; wen = c_wen; ben = c_ben; a = c_a; d = c_d; clr = c_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cmd(1'b1, 1'b1, 4'hF, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [3:0] c_a, input logic [31:0] c_d, input logic [3:0] c_ben);
    cmd(1'b0, 1'b0, c_ben, c_a, c_d, 1'b0);
  endtask

  task automatic rd(input logic [3:0] c_a);
    cmd(1'b0, 1'b1, 4'h0, c_a, 32'h0, 1'b0);
  endtask

  // Counts posedges until each READY rises; -1 marks an expired bound.
  task automatic count_ready(output int na, output int nb);
    na = -1; nb = -1;
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (na < 0 && bus_a.READY) na = n;
      if (nb < 0 && bus_b.READY) nb = n;
      if (na >= 0 && nb >= 0) break;
    end
  endtask

  initial begin
    int na, nb;
    // Power-on reset followed by the initial sweep.
    repeat (3) @(posedge clk);
    #1;
    pin("rst_a_ready", 32'(bus_a.READY), 32'(m_ready[0]), 32'h0);
    pin("rst_a_q",     bus_a.Q,          m_q[0],          32'h0);
    pin("rst_b_qv",    32'(bus_b.QV),    32'(m_qv[1]),    32'h0);
    rst = 1'b0;
    count_ready(na, nb);
    chk("sweep_len_a", 32'(na), 32'd16);
    chk("sweep_len_b", 32'(nb), 32'd12);
    idle();

    // Whole array reads back as fill.
    for (int i = 0; i < 16; i++) rd(4'(i));
    idle(); idle();
    pin("fill_read_a", bus_a.Q, m_q[0], FILL);

    // Byte-masked overwrite of word 5.
    wr(4'd5, 32'hFFFF_FFFF, 4'h0);
    wr(4'd5, 32'h0000_0000, 4'hE);
    rd(4'd5);
    pin("mask_a_q",  bus_a.Q,       m_q[0],       32'hFFFF_FF00);
    pin("mask_a_qv", 32'(bus_a.QV), 32'(m_qv[0]), 32'h1);
    pin("mask_b_qv0", 32'(bus_b.QV), 32'(m_qv[1]), 32'h0);
    idle();
    pin("mask_a_qv1", 32'(bus_a.QV), 32'(m_qv[0]), 32'h0);
    pin("mask_b_q",  bus_b.Q,       m_q[1],       32'hFFFF_FF00);
    pin("mask_b_qv", 32'(bus_b.QV), 32'(m_qv[1]), 32'h1);

    // Q holds captured data across a later write to the same word.
    rd(4'd3);
    wr(4'd3, 32'h1234_5678, 4'h0);
    idle(); idle();
    pin("hold_a", bus_a.Q, m_q[0], FILL);
    pin("hold_b", bus_b.Q, m_q[1], FILL);
    rd(4'd3);
    idle();
    pin("reread_a", bus_a.Q, m_q[0], 32'h1234_5678);
    pin("reread_b", bus_b.Q, m_q[1], 32'h1234_5678);

    // Out-of-range word 13 on the 12-deep instance.
    wr(4'd13, 32'hDEAD_BEEF, 4'h0);
    rd(4'd13);
    idle();
    pin("oor_b_q",  bus_b.Q,       m_q[1],       32'h0);
    pin("oor_b_qv", 32'(bus_b.QV), 32'(m_qv[1]), 32'h1);
    pin("oor_a_q",  bus_a.Q,       m_q[0],       32'hDEAD_BEEF);
    for (int i = 0; i < 12; i++) rd(4'(i));
    idle(); idle();

    // Back-to-back reads through the latency-2 pipe.
    wr(4'd0, 32'h1111_1111, 4'h0);
    wr(4'd1, 32'h2222_2222, 4'h0);
    wr(4'd2, 32'h3333_3333, 4'h0);
    rd(4'd0);
    pin("b2b_qv0", 32'(bus_b.QV), 32'(m_qv[1]), 32'h0);
    rd(4'd1);
    pin("b2b_q1", bus_b.Q, m_q[1], 32'h1111_1111);
    pin("b2b_v1", 32'(bus_b.QV), 32'(m_qv[1]), 32'h1);
    rd(4'd2);
    pin("b2b_q2", bus_b.Q, m_q[1], 32'h2222_2222);
    pin("b2b_v2", 32'(bus_b.QV), 32'(m_qv[1]), 32'h1);
    idle();
    pin("b2b_q3", bus_b.Q, m_q[1], 32'h3333_3333);
    pin("b2b_v3", 32'(bus_b.QV), 32'(m_qv[1]), 32'h1);
    idle();
    pin("b2b_v4", 32'(bus_b.QV), 32'(m_qv[1]), 32'h0);

    // CLR with a same-cycle write (dropped), then reset at sweep count 7.
    rd(4'd4);
    cmd(1'b0, 1'b0, 4'h0, 4'd0, 32'hCAFE_F00D, 1'b1);
    pin("clr_ready", 32'(bus_a.READY), 32'(m_ready[0]), 32'h0);
    cmd(1'b0, 1'b0, 4'h0, 4'd9, 32'h0BAD_0BAD, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    pin("midrst_ready", 32'(bus_b.READY), 32'(m_ready[1]), 32'h0);
    rst = 1'b0;
    count_ready(na, nb);
    chk("resweep_len_a", 32'(na), 32'd16);
    chk("resweep_len_b", 32'(nb), 32'd12);
    idle();
    rd(4'd0);
    idle();
    pin("clr_drop_a", bus_a.Q, m_q[0], FILL);
    pin("clr_drop_b", bus_b.Q, m_q[1], FILL);

    // Randomized traffic including occasional clears and resets.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        cen = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rst = 1'b0;
      end else begin
        cmd(($urandom_range(0, 9) < 7) ? 1'b0 : 1'b1,
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)),
            32'($urandom),
            ($urandom_range(0, 79) == 0) ? 1'b1 : 1'b0);
      end
    end
    idle(); idle();

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
